// File: rtl/map_drawer.sv
// Background redraw engine: sweeps the screen once per drawMap request, streaming map ROM pixels to the VGA adapter.
// Optional build macro MAP_SKIP_KEY_EN: suppress plots of KEY_COLOUR pixels so existing overlay pixels survive.
module map_drawer #(
    parameter int                  COLOUR_W   = 3,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0,
    parameter int                  H_RES      = 320,
    parameter int                  V_RES      = 240
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                drawMap,
    input  logic [3:0]          gameState,
    output logic [2:0]          map_sel,
    output logic [16:0]         rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [8:0]          vga_x,
    output logic [7:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                doneRedraw
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0] X_LAST = 9'(H_RES - 1);
    localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

`ifdef MAP_SKIP_KEY_EN
    localparam logic SKIP_KEY = 1'b1;
`else
    localparam logic SKIP_KEY = 1'b0;
`endif

    logic [1:0]  st_q, st_d;
    logic [3:0]  state_q, state_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [16:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic        plot_q, plot_d;
    logic [8:0]  vx_q, vx_d;
    logic [7:0]  vy_q, vy_d;
    logic        start;
    logic        last_pix;

    function automatic logic [2:0] decode_map(input logic [3:0] s);
        case (s)
            4'd1, 4'd2: decode_map = 3'd1;
            4'd3, 4'd4: decode_map = 3'd2;
            4'd5, 4'd6: decode_map = 3'd3;
            4'd7, 4'd8: decode_map = 3'd4;
            4'd9:       decode_map = 3'd5;
            default:    decode_map = 3'd0;
        endcase
    endfunction

    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        plot_d  = 1'b0;
        vx_d    = x_q;
        vy_d    = y_q;
        start   = 1'b0;
        case (st_q)
            S_IDLE: start = drawMap;
            S_DRAW: begin
                plot_d = 1'b1;
                if (!drawMap) drop_d = 1'b1;
                if (last_pix) begin
                    st_d = S_FLUSH;
                end else begin
                    addr_d = addr_q + 17'd1;
                    if (x_q == X_LAST) begin
                        x_d = 9'd0;
                        y_d = y_q + 8'd1;
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (!drawMap) drop_d = 1'b1;
                st_d = S_DONE;
            end
            default: begin
                // A request dropped mid-sweep gets a single DONE cycle only.
                if (drop_q || !drawMap) st_d = S_IDLE;
                else if (gameState != state_q) start = 1'b1;
            end
        endcase
        if (start) begin
            st_d    = S_DRAW;
            state_d = gameState;
            x_d     = 9'd0;
            y_d     = 8'd0;
            addr_d  = 17'd0;
            drop_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st_q    <= S_IDLE;
            state_q <= 4'd0;
            x_q     <= 9'd0;
            y_q     <= 8'd0;
            addr_q  <= 17'd0;
            drop_q  <= 1'b0;
            plot_q  <= 1'b0;
            vx_q    <= 9'd0;
            vy_q    <= 8'd0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            plot_q  <= plot_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
        end
    end

    assign map_sel    = decode_map(state_q);
    assign rom_addr   = addr_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = rom_data;
    assign vga_plot   = plot_q & ~(SKIP_KEY & (rom_data == KEY_COLOUR));
    assign doneRedraw = (st_q == S_DONE);

endmodule

// File: tb/tb_map_drawer.sv
// Directed bench for map_drawer: small-screen instance for full sweeps/handshakes, default-size instance for row wrap.
module tb_map_drawer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

`ifdef MAP_SKIP_KEY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        drawMap, drawMap_b;
    logic [3:0]  gameState, gameState_b;
    logic [2:0]  map_sel, map_sel_b;
    logic [16:0] rom_addr, rom_addr_b;
    logic [2:0]  rom_s, rom_b;
    logic [8:0]  vga_x, vga_x_b;
    logic [7:0]  vga_y, vga_y_b;
    logic [2:0]  vga_colour, vga_colour_b;
    logic        vga_plot, vga_plot_b;
    logic        doneRedraw, done_b;

    int n_checks = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    map_drawer #(.COLOUR_W(3), .KEY_COLOUR(3'd0), .H_RES(W), .V_RES(H)) dut_s (
        .clock(clock), .resetn(resetn), .drawMap(drawMap), .gameState(gameState),
        .map_sel(map_sel), .rom_addr(rom_addr), .rom_data(rom_s),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .doneRedraw(doneRedraw)
    );

    map_drawer dut_b (
        .clock(clock), .resetn(resetn), .drawMap(drawMap_b), .gameState(gameState_b),
        .map_sel(map_sel_b), .rom_addr(rom_addr_b), .rom_data(rom_b),
        .vga_x(vga_x_b), .vga_y(vga_y_b), .vga_colour(vga_colour_b),
        .vga_plot(vga_plot_b), .doneRedraw(done_b)
    );

    function automatic logic [2:0] pix(input logic [16:0] a, input logic [2:0] m);
        logic [16:0] s;
        s = a + {14'd0, m};
        return s[2:0] ^ s[5:3];
    endfunction

    function automatic logic exp_plot(input int idx, input logic [2:0] sel);
        return (pix(17'(idx), sel) != 3'd0) || !SKIP;
    endfunction

    // Synchronous map ROMs: data one cycle after address/select.
    always @(posedge clock) begin
        rom_s <= pix(rom_addr, map_sel);
        rom_b <= pix(rom_addr_b, map_sel_b);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // mode 0: hold request after done then drop; 1: 5-cycle pulse; 2: leave held in DONE
    task automatic do_sweep(input logic [3:0] gs, input logic [2:0] sel, input int mode, input bit chg);
        int done_c = 0, nplot = 0, exp_n = 0, first_c = 0, last_c = 0;
        int exp_first = 0, exp_last = 0, sel_err = 0, pix_err = 0, hold_err = 0;
        gameState = gs;
        drawMap   = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= N + 10 && done_c == 0; c++) begin
            @(negedge clock);
            if (c <= N && (map_sel !== sel || rom_addr !== 17'(c - 1))) sel_err++;
            if (c >= 2 && c <= N + 1) begin
                int  idx;
                logic ep;
                idx = c - 2;
                ep  = exp_plot(idx, sel);
                if (ep) begin
                    exp_n++;
                    if (exp_first == 0) exp_first = c;
                    exp_last = c;
                end
                if (vga_plot !== ep) pix_err++;
                if (vga_plot === 1'b1 && (vga_x !== 9'(idx % W) || vga_y !== 8'(idx / W) ||
                                          vga_colour !== pix(17'(idx), sel))) pix_err++;
            end else if (vga_plot !== 1'b0) begin
                pix_err++;
            end
            if (vga_plot === 1'b1) begin
                nplot++;
                if (first_c == 0) first_c = c;
                last_c = c;
            end
            if (doneRedraw === 1'b1) done_c = c;
            if (mode == 1 && c == 5) drawMap = 1'b0;
            if (chg && c == 3) gameState = gs + 4'd1;
            if (chg && c == N - 4) gameState = gs;
        end
        chk($sformatf("gs%0d addr/map_sel", gs), sel_err, 0);
        chk($sformatf("gs%0d plot count", gs), nplot, exp_n);
        chk($sformatf("gs%0d first plot cycle", gs), first_c, exp_first);
        chk($sformatf("gs%0d last plot cycle", gs), last_c, exp_last);
        chk($sformatf("gs%0d pixel stream errs", gs), pix_err, 0);
        chk($sformatf("gs%0d done cycle", gs), done_c, N + 2);
        if (mode == 0) begin
            repeat (100) begin
                @(negedge clock);
                if (doneRedraw !== 1'b1 || vga_plot !== 1'b0) hold_err++;
            end
            chk($sformatf("gs%0d hold errs", gs), hold_err, 0);
            drawMap = 1'b0;
            @(negedge clock);
            chk($sformatf("gs%0d done after drop", gs), doneRedraw, 0);
            @(negedge clock);
            chk($sformatf("gs%0d idle plot", gs), vga_plot, 0);
        end else if (mode == 1) begin
            @(negedge clock);
            chk($sformatf("gs%0d pulse done width", gs), doneRedraw, 0);
            @(negedge clock);
            chk($sformatf("gs%0d pulse idle", gs), {vga_plot, doneRedraw}, 0);
        end
    endtask

    typedef struct {
        logic [3:0] gs;
        logic [2:0] sel;
        int         mode;
        bit         chg;
    } vec_t;

    initial begin
        vec_t vecs[17];
        int   err;
        vecs = '{
            '{4'd0,  3'd0, 0, 1'b0}, '{4'd1,  3'd1, 0, 1'b1}, '{4'd2,  3'd1, 1, 1'b0},
            '{4'd3,  3'd2, 0, 1'b0}, '{4'd4,  3'd2, 0, 1'b0}, '{4'd5,  3'd3, 1, 1'b0},
            '{4'd6,  3'd3, 0, 1'b0}, '{4'd7,  3'd4, 0, 1'b0}, '{4'd8,  3'd4, 2, 1'b0},
            '{4'd9,  3'd5, 0, 1'b0}, '{4'd9,  3'd5, 1, 1'b0}, '{4'd10, 3'd0, 0, 1'b0},
            '{4'd11, 3'd0, 1, 1'b0}, '{4'd12, 3'd0, 0, 1'b0}, '{4'd13, 3'd0, 0, 1'b0},
            '{4'd14, 3'd0, 0, 1'b0}, '{4'd15, 3'd0, 2, 1'b0}
        };
        resetn = 1'b0; drawMap = 1'b0; gameState = 4'd0;
        drawMap_b = 1'b0; gameState_b = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset done", doneRedraw, 0);
        chk("reset plot", vga_plot, 0);
        chk("reset x/y", {vga_x, vga_y}, 0);
        chk("reset map_sel", map_sel, 0);
        chk("reset rom_addr", rom_addr, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[i]) do_sweep(vecs[i].gs, vecs[i].sel, vecs[i].mode, vecs[i].chg);

        // Restart from held DONE (state 15) then reset mid-sweep.
        gameState = 4'd3;
        @(posedge clock);
        repeat (10) @(negedge clock);
        chk("pre-reset rom_addr", rom_addr, 9);
        chk("pre-reset map_sel", map_sel, 2);
        resetn = 1'b0;
        #1;
        chk("async reset plot", vga_plot, 0);
        chk("async reset x/y", {vga_x, vga_y}, 0);
        chk("async reset addr/sel", {rom_addr, map_sel}, 0);
        chk("async reset done", doneRedraw, 0);
        drawMap = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        err = 0;
        repeat (20) begin
            @(negedge clock);
            if (vga_plot !== 1'b0 || doneRedraw !== 1'b0) err++;
        end
        chk("post-reset idle", err, 0);

        // Default 320x240 geometry: row wrap and address continuity.
        gameState_b = 4'd3;
        drawMap_b   = 1'b1;
        @(posedge clock);
        err = 0;
        for (int c = 1; c <= 330; c++) begin
            @(negedge clock);
            if (rom_addr_b !== 17'(c - 1) || map_sel_b !== 3'd2 || done_b !== 1'b0) err++;
            if (c >= 2 && vga_plot_b !== exp_plot(c - 2, 3'd2)) err++;
            if (c == 2) chk("big first pixel", {vga_x_b, vga_y_b, vga_colour_b},
                            {9'd0, 8'd0, pix(17'd0, 3'd2)});
            if (c == 321) chk("big row end", {vga_x_b, vga_y_b, vga_colour_b},
                              {9'd319, 8'd0, pix(17'd319, 3'd2)});
            if (c == 322) chk("big row wrap", {vga_x_b, vga_y_b, vga_colour_b},
                              {9'd0, 8'd1, pix(17'd320, 3'd2)});
        end
        chk("big sweep stream errs", err, 0);
        drawMap_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
